// File: rtl/vend_dispense_ctrl_if.sv
// Request/actuator/status bundle between the coin FSM, the dispense controller and the front panel.
// The master drives requests, sensor and refill inputs; the slave is the dispense controller.
interface vend_dispense_ctrl_if #(
  parameter int STOCK_W = 4
);
  logic               product_release;
  logic               change_return;
  logic               drop_sense;
  logic               fault_clr;
  logic               load_stock;
  logic [STOCK_W-1:0] stock_load_val;
  logic               motor_on;
  logic               hopper_on;
  logic               busy;
  logic               sold_out;
  logic               fault;
  logic [STOCK_W-1:0] stock_cnt;

  modport master (
    output product_release, change_return, drop_sense, fault_clr, load_stock, stock_load_val,
    input  motor_on, hopper_on, busy, sold_out, fault, stock_cnt
  );

  modport slave (
    input  product_release, change_return, drop_sense, fault_clr, load_stock, stock_load_val,
    output motor_on, hopper_on, busy, sold_out, fault, stock_cnt
  );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Dispense actuator controller: queues product/change requests, runs the motor until the drop
// sensor fires, pulses the change hopper for a fixed time, tracks stock and reports faults.
module vend_dispense_ctrl #(
  parameter int MOTOR_MAX     = 50,
  parameter int HOPPER_CYCLES = 8,
  parameter int STOCK_W       = 4,
  parameter int STOCK_INIT    = 10
) (
  input  logic                clk,
  input  logic                rstn,
  vend_dispense_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] VEND   = 2'd1;
  localparam logic [1:0] CHANGE = 2'd2;
  localparam logic [1:0] FAULT  = 2'd3;

  localparam int TMAX = (MOTOR_MAX > HOPPER_CYCLES) ? MOTOR_MAX : HOPPER_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] MOTOR_LAST  = TW'(MOTOR_MAX - 1);
  localparam logic [TW-1:0] HOPPER_LAST = TW'(HOPPER_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [STOCK_W-1:0] stock_q, stock_d;
  logic               prod_pend_q, prod_pend_d;
  logic               chg_pend_q, chg_pend_d;
  logic               motor_q, hopper_q, fault_q;
  logic               prod_clr, chg_clr, overrun;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    timer_d  = timer_q;
    stock_d  = stock_q;
    prod_clr = 1'b0;
    chg_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (prod_pend_q) begin
          prod_clr = 1'b1;
          if (stock_q != '0) begin
            state_d = VEND;
            timer_d = '0;
          end else begin
            state_d = FAULT;
          end
        end else if (chg_pend_q) begin
          chg_clr = 1'b1;
          state_d = CHANGE;
          timer_d = '0;
        end else if (bus.load_stock) begin
          stock_d = bus.stock_load_val;
        end
      end
      VEND: begin
        timer_d = timer_q + 1'b1;
        if (bus.drop_sense) begin
          if (stock_q != '0) stock_d = stock_q - 1'b1;
          if (chg_pend_q) begin
            chg_clr = 1'b1;
            state_d = CHANGE;
            timer_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (timer_q == MOTOR_LAST) begin
          state_d = FAULT;
        end
      end
      CHANGE: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == HOPPER_LAST) state_d = IDLE;
      end
      default: begin
        if (bus.fault_clr) begin
          prod_clr = 1'b1;
          chg_clr  = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase

    // A pulse on a flag that is set and not being consumed this edge is a lost request.
    overrun = (state_q != FAULT) &&
              ((bus.product_release && prod_pend_q && !prod_clr) ||
               (bus.change_return   && chg_pend_q  && !chg_clr));
    if (overrun) state_d = FAULT;

    prod_pend_d = bus.product_release | (prod_pend_q & ~prod_clr);
    chg_pend_d  = bus.change_return   | (chg_pend_q  & ~chg_clr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      stock_q     <= STOCK_W'(STOCK_INIT);
      prod_pend_q <= 1'b0;
      chg_pend_q  <= 1'b0;
      motor_q     <= 1'b0;
      hopper_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      timer_q     <= timer_d;
      stock_q     <= stock_d;
      prod_pend_q <= prod_pend_d;
      chg_pend_q  <= chg_pend_d;
      motor_q     <= (state_q == VEND);
      hopper_q    <= (state_q == CHANGE);
      fault_q     <= (state_q == FAULT);
    end
  end

  assign bus.motor_on  = motor_q;
  assign bus.hopper_on = hopper_q;
  assign bus.fault     = fault_q;
  assign bus.stock_cnt = stock_q;
  assign bus.sold_out  = (stock_q == '0);
  assign bus.busy      = (state_q != IDLE) | prod_pend_q | chg_pend_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: actuator pulse lengths are scored against a queue of
// expected lengths filled as requests are issued; status outputs are checked inline.
module tb_vend_dispense_ctrl;

  localparam int STOCK_W = 4;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_motor[$];
  int   exp_hopper[$];

  always #5 clk = ~clk;

  vend_dispense_ctrl_if #(.STOCK_W(STOCK_W)) bus ();

  vend_dispense_ctrl #(
    .MOTOR_MAX(50), .HOPPER_CYCLES(8), .STOCK_W(STOCK_W), .STOCK_INIT(10)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return bus.motor_on;
      1:       return bus.hopper_on;
      default: return bus.fault;
    endcase
  endfunction

  // Bounded wait at negedges; an expired budget shows up as a failed comparison.
  task automatic wait_sig(input int sel, input logic level, input int budget, input string tag);
    for (int i = 0; i < budget && get_sig(sel) !== level; i++) @(negedge clk);
    check(tag, get_sig(sel), level);
  endtask

  task automatic pulse_req(input logic prod, input logic chg);
    bus.product_release = prod;
    bus.change_return   = chg;
    @(negedge clk);
    bus.product_release = 1'b0;
    bus.change_return   = 1'b0;
  endtask

  // Motor lags the VEND state by one cycle: a drop sampled at the end of VEND cycle k
  // gives exactly k motor cycles.
  task automatic vend_with_drop(input int k);
    wait_sig(0, 1'b1, 6, "motor_rise");
    repeat (k - 2) @(negedge clk);
    bus.drop_sense = 1'b1;
    @(negedge clk);
    bus.drop_sense = 1'b0;
  endtask

  task automatic clear_fault();
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    check("clr_busy", bus.busy, 1'b0);
    @(negedge clk);
    check("clr_fault", bus.fault, 1'b0);
  endtask

  // Pulse-length scoreboard for both actuators.
  initial begin
    int mlen = 0;
    int hlen = 0;
    forever begin
      @(negedge clk);
      if (bus.motor_on === 1'b1) mlen++;
      else if (mlen != 0) begin
        if (exp_motor.size() == 0) check("motor_unexpected", mlen, 0);
        else check("motor_len", mlen, exp_motor.pop_front());
        mlen = 0;
      end
      if (bus.hopper_on === 1'b1) hlen++;
      else if (hlen != 0) begin
        if (exp_hopper.size() == 0) check("hopper_unexpected", hlen, 0);
        else check("hopper_len", hlen, exp_hopper.pop_front());
        hlen = 0;
      end
    end
  end

  initial begin
    rstn = 1'b0;
    bus.product_release = 1'b0;
    bus.change_return   = 1'b0;
    bus.drop_sense      = 1'b0;
    bus.fault_clr       = 1'b0;
    bus.load_stock      = 1'b0;
    bus.stock_load_val  = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 1: single vend, drop ends the 5th VEND cycle
    check("rst_motor", bus.motor_on, 1'b0);
    check("rst_hopper", bus.hopper_on, 1'b0);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_stock", bus.stock_cnt, 10);
    check("rst_sold_out", bus.sold_out, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    exp_motor.push_back(5);
    pulse_req(1'b1, 1'b0);
    check("t1_busy_pend", bus.busy, 1'b1);
    @(negedge clk);
    check("t1_latency_motor_low", bus.motor_on, 1'b0);
    @(negedge clk);
    check("t1_latency_motor_high", bus.motor_on, 1'b1);
    vend_with_drop(5);
    wait_sig(0, 1'b0, 5, "t1_motor_fall");
    check("t1_stock", bus.stock_cnt, 9);
    check("t1_busy_idle", bus.busy, 1'b0);
    check("t1_hopper", bus.hopper_on, 1'b0);

    // 2: product + change together
    exp_motor.push_back(3);
    exp_hopper.push_back(8);
    pulse_req(1'b1, 1'b1);
    vend_with_drop(3);
    wait_sig(0, 1'b0, 5, "t2_motor_fall");
    check("t2_hopper_start", bus.hopper_on, 1'b1);
    wait_sig(1, 1'b0, 20, "t2_hopper_fall");
    check("t2_stock", bus.stock_cnt, 8);
    check("t2_busy", bus.busy, 1'b0);

    // 3: no drop -> timeout fault after 50 motor cycles
    exp_motor.push_back(50);
    pulse_req(1'b1, 1'b0);
    wait_sig(0, 1'b1, 6, "t3_motor_rise");
    wait_sig(2, 1'b1, 60, "t3_fault");
    check("t3_motor_off", bus.motor_on, 1'b0);
    check("t3_stock", bus.stock_cnt, 8);
    clear_fault();

    // 4: refill to 2, sell out, then a request with no stock faults
    bus.load_stock = 1'b1;
    bus.stock_load_val = 4'd2;
    @(negedge clk);
    bus.load_stock = 1'b0;
    check("t4_loaded", bus.stock_cnt, 2);
    for (int v = 0; v < 2; v++) begin
      exp_motor.push_back(3);
      pulse_req(1'b1, 1'b0);
      vend_with_drop(3);
      wait_sig(0, 1'b0, 5, "t4_motor_fall");
    end
    check("t4_stock_zero", bus.stock_cnt, 0);
    check("t4_sold_out", bus.sold_out, 1'b1);
    pulse_req(1'b1, 1'b0);
    wait_sig(2, 1'b1, 10, "t4_fault");
    check("t4_no_motor", bus.motor_on, 1'b0);
    clear_fault();

    // 5: overrun during VEND, load_stock ignored outside IDLE
    bus.load_stock = 1'b1;
    bus.stock_load_val = 4'd7;
    @(negedge clk);
    bus.load_stock = 1'b0;
    check("t5_loaded", bus.stock_cnt, 7);
    exp_motor.push_back(4);
    pulse_req(1'b1, 1'b0);
    wait_sig(0, 1'b1, 6, "t5_motor_rise");
    bus.product_release = 1'b1;
    @(negedge clk);
    bus.product_release = 1'b0;
    bus.load_stock = 1'b1;
    bus.stock_load_val = 4'd3;
    @(negedge clk);
    bus.load_stock = 1'b0;
    pulse_req(1'b1, 1'b0);
    wait_sig(2, 1'b1, 10, "t5_overrun_fault");
    check("t5_stock_kept", bus.stock_cnt, 7);
    clear_fault();
    repeat (4) @(negedge clk);
    check("t5_no_pending", bus.busy, 1'b0);

    // 6: reset during the hopper burst with a product request pending
    exp_hopper.push_back(3);
    pulse_req(1'b0, 1'b1);
    wait_sig(1, 1'b1, 6, "t6_hopper_rise");
    pulse_req(1'b1, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t6_hopper_async", bus.hopper_on, 1'b0);
    check("t6_stock_init", bus.stock_cnt, 10);
    check("t6_busy_rst", bus.busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_busy_after", bus.busy, 1'b0);
    check("t6_motor_after", bus.motor_on, 1'b0);

    check("motor_queue_empty", exp_motor.size(), 0);
    check("hopper_queue_empty", exp_hopper.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
